// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte over open-drain PS2C/PS2D using glitch-filtered line sampling.
// PS2D_oe updates the cycle after a filtered clock fall; tx_valid is only accepted when tx_ready (IDLE).
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 3000,
   parameter int TIMEOUT_CYCLES = 375000,
   parameter int FILTER_LEN     = 8
) (
   input  logic       clk_25mhz,
   input  logic       clr,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       PS2C,
   input  logic       PS2D,
   output logic       PS2C_oe,
   output logic       PS2D_oe,
   output logic       tx_done,
   output logic       tx_err,
   output logic       busy
);

   localparam int CMAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, INHIBIT, START, DATA, ACK, WAIT_IDLE} state_t;

   logic [FILTER_LEN-1:0] sh_c, sh_d;
   logic                  filt_c, filt_d, prev_c;
   logic                  fall;
   state_t                state;
   logic [CW-1:0]         cnt;
   logic [3:0]            bitcnt;
   logic [7:0]            data_q;
   logic                  parity_q;
   logic [9:0]            frame;

   assign fall  = prev_c & ~filt_c;
   assign frame = {1'b1, parity_q, data_q};

   // The raw pads are asynchronous; a filtered value only moves after a full window of agreeing samples.
   always_ff @(posedge clk_25mhz or posedge clr) begin
      if (clr) begin
         sh_c   <= '1;
         sh_d   <= '1;
         filt_c <= 1'b1;
         filt_d <= 1'b1;
         prev_c <= 1'b1;
      end else begin
         sh_c <= {sh_c[FILTER_LEN-2:0], PS2C};
         sh_d <= {sh_d[FILTER_LEN-2:0], PS2D};
         if (&sh_c)
            filt_c <= 1'b1;
         else if (~|sh_c)
            filt_c <= 1'b0;
         if (&sh_d)
            filt_d <= 1'b1;
         else if (~|sh_d)
            filt_d <= 1'b0;
         prev_c <= filt_c;
      end
   end

   always_ff @(posedge clk_25mhz or posedge clr) begin
      if (clr) begin
         state    <= IDLE;
         cnt      <= '0;
         bitcnt   <= '0;
         data_q   <= '0;
         parity_q <= 1'b0;
         PS2C_oe  <= 1'b0;
         PS2D_oe  <= 1'b0;
         tx_done  <= 1'b0;
         tx_err   <= 1'b0;
         busy     <= 1'b0;
         tx_ready <= 1'b1;
      end else begin
         tx_done <= 1'b0;
         tx_err  <= 1'b0;
         case (state)
            IDLE: begin
               PS2C_oe <= 1'b0;
               PS2D_oe <= 1'b0;
               if (tx_valid && tx_ready) begin
                  data_q   <= tx_data;
                  parity_q <= ~^tx_data;
                  cnt      <= '0;
                  PS2C_oe  <= 1'b1;
                  busy     <= 1'b1;
                  tx_ready <= 1'b0;
                  state    <= INHIBIT;
               end
            end
            INHIBIT: begin
               // Start bit goes low on the same edge the clock is released.
               if (cnt == INH_LAST) begin
                  cnt     <= '0;
                  PS2C_oe <= 1'b0;
                  PS2D_oe <= 1'b1;
                  state   <= START;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            START: begin
               if (fall) begin
                  cnt     <= '0;
                  PS2D_oe <= ~frame[0];
                  bitcnt  <= 4'd1;
                  state   <= DATA;
               end else if (cnt == TO_LAST) begin
                  tx_err   <= 1'b1;
                  PS2C_oe  <= 1'b0;
                  PS2D_oe  <= 1'b0;
                  busy     <= 1'b0;
                  tx_ready <= 1'b1;
                  cnt      <= '0;
                  state    <= IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DATA: begin
               if (fall) begin
                  cnt     <= '0;
                  PS2D_oe <= ~frame[bitcnt];
                  bitcnt  <= bitcnt + 4'd1;
                  if (bitcnt == 4'd9)
                     state <= ACK;
               end else if (cnt == TO_LAST) begin
                  tx_err   <= 1'b1;
                  PS2C_oe  <= 1'b0;
                  PS2D_oe  <= 1'b0;
                  busy     <= 1'b0;
                  tx_ready <= 1'b1;
                  cnt      <= '0;
                  state    <= IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ACK: begin
               if (fall) begin
                  cnt <= '0;
                  if (!filt_d) begin
                     state <= WAIT_IDLE;
                  end else begin
                     tx_err   <= 1'b1;
                     PS2D_oe  <= 1'b0;
                     busy     <= 1'b0;
                     tx_ready <= 1'b1;
                     state    <= IDLE;
                  end
               end else if (cnt == TO_LAST) begin
                  tx_err   <= 1'b1;
                  PS2C_oe  <= 1'b0;
                  PS2D_oe  <= 1'b0;
                  busy     <= 1'b0;
                  tx_ready <= 1'b1;
                  cnt      <= '0;
                  state    <= IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            WAIT_IDLE: begin
               if (filt_c && filt_d) begin
                  tx_done  <= 1'b1;
                  busy     <= 1'b0;
                  tx_ready <= 1'b1;
                  cnt      <= '0;
                  state    <= IDLE;
               end else if (fall) begin
                  cnt <= '0;
               end else if (cnt == TO_LAST) begin
                  tx_err   <= 1'b1;
                  PS2C_oe  <= 1'b0;
                  PS2D_oe  <= 1'b0;
                  busy     <= 1'b0;
                  tx_ready <= 1'b1;
                  cnt      <= '0;
                  state    <= IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               PS2C_oe  <= 1'b0;
               PS2D_oe  <= 1'b0;
               busy     <= 1'b0;
               tx_ready <= 1'b1;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model plus a keyboard model that clocks frames and acknowledges.
module tb_ps2_host_tx;

   localparam int INH = 3000;
   localparam int TO  = 4000;
   localparam int H   = 32;

   logic       clk_25mhz = 1'b0;
   logic       clr = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, PS2C_oe, PS2D_oe, tx_done, tx_err, busy;
   logic       dev_c = 1'b0, dev_d = 1'b0, glitch = 1'b0;
   logic       ps2c, ps2d;

   int n_assert = 0, n_fail = 0;
   int done_cnt = 0, err_cnt = 0, both_cnt = 0;

   assign ps2c = ~(PS2C_oe | dev_c | glitch);
   assign ps2d = ~(PS2D_oe | dev_d);

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(8)) dut (
      .clk_25mhz(clk_25mhz), .clr(clr), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .PS2C(ps2c), .PS2D(ps2d), .PS2C_oe(PS2C_oe),
      .PS2D_oe(PS2D_oe), .tx_done(tx_done), .tx_err(tx_err), .busy(busy)
   );

   always #20 clk_25mhz = ~clk_25mhz;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_25mhz);
      #1;
      if (tx_done) done_cnt++;
      if (tx_err) err_cnt++;
      if (tx_done && tx_err) both_cnt++;
   endtask

   // Expected line values at device sample points: data LSB first, odd parity, stop.
   function automatic logic [9:0] model_frame(input logic [7:0] b);
      int ones = 0;
      logic [9:0] f;
      for (int i = 0; i < 8; i++) begin
         f[i] = ((int'(b) >> i) & 1) != 0;
         if (f[i]) ones++;
      end
      f[8] = (ones % 2 == 0);
      f[9] = 1'b1;
      return f;
   endfunction

   task automatic send(input logic [7:0] b);
      int n = 0;
      while (!tx_ready && n < 5000) begin
         tick();
         n++;
      end
      check("ready_before_send", tx_ready, 1);
      tx_data  = b;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      check("busy_after_accept", busy, 1);
      check("ready_low_after_accept", tx_ready, 0);
   endtask

   // mode: 0 ack, 1 silent device, 2 no ack, 3 clr at data bit 4, 4 clock glitch, 5 second request
   task automatic run_device(input int mode, input logic [7:0] b2, output logic [9:0] fr);
      int n;
      done_cnt = 0;
      err_cnt  = 0;
      fr       = '0;
      check("inhibit_clk_pull", PS2C_oe, 1);
      check("inhibit_data_free", PS2D_oe, 0);
      n = 0;
      while (PS2C_oe && n < INH + 100) begin
         tick();
         n++;
      end
      check("inhibit_len", n, INH);
      check("start_bit", PS2D_oe, 1);
      if (mode == 1) begin
         n = 0;
         while (!tx_err && n < TO + 100) begin
            tick();
            n++;
         end
         check("timeout_cycles", n, TO);
         check("timeout_clk_oe", PS2C_oe, 0);
         check("timeout_dat_oe", PS2D_oe, 0);
         check("timeout_ready", tx_ready, 1);
         return;
      end
      repeat (20) tick();
      for (int k = 1; k <= 11; k++) begin
         dev_c = 1'b1;
         for (int j = 0; j < H; j++) begin
            if (mode == 5 && k == 3 && j == H / 2) begin
               check("ready_while_busy", tx_ready, 0);
               tx_data  = b2;
               tx_valid = 1'b1;
            end
            if (mode == 3 && k == 5 && j == H / 2) begin
               clr = 1'b1;
               #1;
               check("abort_clk_oe", PS2C_oe, 0);
               check("abort_dat_oe", PS2D_oe, 0);
               check("abort_busy", busy, 0);
               check("abort_ready", tx_ready, 1);
               repeat (3) tick();
               dev_c = 1'b0;
               clr   = 1'b0;
               repeat (20) tick();
               return;
            end
            tick();
         end
         if (k <= 10) fr[k-1] = ps2d;
         dev_c = 1'b0;
         if (k == 11) dev_d = 1'b0;
         for (int j = 0; j < H; j++) begin
            if (k == 11 && (done_cnt != 0 || err_cnt != 0)) break;
            if (mode == 4 && k == 4 && j == 10) glitch = 1'b1;
            if (mode == 4 && k == 4 && j == 15) glitch = 1'b0;
            if (mode != 2 && k == 10 && j == H / 2) dev_d = 1'b1;
            tick();
         end
      end
      n = 0;
      while (done_cnt == 0 && err_cnt == 0 && n < 200) begin
         tick();
         n++;
      end
   endtask

   task automatic good_xfer(input string tag, input logic [7:0] b);
      logic [9:0] fr;
      send(b);
      run_device(0, 8'h00, fr);
      check({tag, "_frame"}, fr, model_frame(b));
      check({tag, "_done"}, done_cnt, 1);
      check({tag, "_err"}, err_cnt, 0);
      check({tag, "_ready"}, tx_ready, 1);
   endtask

   initial begin
      logic [9:0] fr;
      logic [7:0] b1, b2;
      int n;

      #2 clr = 1'b1;
      #1;
      check("rst_clk_oe", PS2C_oe, 0);
      check("rst_dat_oe", PS2D_oe, 0);
      check("rst_done", tx_done, 0);
      check("rst_err", tx_err, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", tx_ready, 1);
      #47 clr = 1'b0;
      repeat (5) tick();

      good_xfer("ed", 8'hED);
      good_xfer("x07", 8'h07);
      good_xfer("ff", 8'hFF);

      send(8'($urandom));
      run_device(1, 8'h00, fr);
      check("timeout_err_cnt", err_cnt, 1);
      check("timeout_done_cnt", done_cnt, 0);

      b1 = 8'($urandom);
      send(b1);
      run_device(2, 8'h00, fr);
      check("nack_frame", fr, model_frame(b1));
      check("nack_err", err_cnt, 1);
      check("nack_done", done_cnt, 0);
      check("nack_ready", tx_ready, 1);

      b1 = 8'($urandom);
      b2 = b1 ^ 8'h5A;
      send(b1);
      run_device(5, b2, fr);
      check("first_byte_frame", fr, model_frame(b1));
      check("first_byte_done", done_cnt, 1);
      check("second_wait_ready", tx_ready, 1);
      n = 0;
      while (!busy && n < 10) begin
         tick();
         n++;
      end
      tx_valid = 1'b0;
      check("second_accepted", busy, 1);
      run_device(0, 8'h00, fr);
      check("second_byte_frame", fr, model_frame(b2));
      check("second_byte_done", done_cnt, 1);

      send(8'hED);
      run_device(3, 8'h00, fr);
      check("abort_no_done", done_cnt, 0);
      good_xfer("after_abort", 8'hFF);

      b1 = 8'($urandom);
      send(b1);
      run_device(4, 8'h00, fr);
      check("glitch_frame", fr, model_frame(b1));
      check("glitch_done", done_cnt, 1);
      check("glitch_err", err_cnt, 0);

      good_xfer("rand", 8'($urandom));

      check("done_err_exclusive", both_cnt, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
